cap_scan_ctrl: RTL and testbench
================================

CAP_SCAN_CTRL -- requirements
Module: cap_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of capacitive sense channels, 1..8.
REQ-002 SHALL have parameter DRIVE_CYCLES, default 3: cycles each channel is driven low before sampling, 1..15.
REQ-003 SHALL have parameter THRESH, default 115: touch threshold in sample counts, 0..255.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-low (0 = reset asserted).
REQ-006 SHALL have port enable  input  1  run scans while high.
REQ-007 SHALL have port sense_in  input  NUM_CH  raw pin levels from the SB_IO D_IN_0 outputs.
REQ-008 SHALL have port drive_oe  output  NUM_CH  one-hot output enable to the SB_IO blocks (D_OUT_0 is tied 0 externally).
REQ-009 SHALL have port count  output  8  last completed sample value.
REQ-010 SHALL have port count_ch  output  3  channel index of count.
REQ-011 SHALL have port count_valid  output  1  one-cycle strobe: count and count_ch are updated.
REQ-012 SHALL have port touched  output  NUM_CH  per-channel touch flag.
REQ-013 SHALL have port scan_done  output  1  one-cycle strobe after the last channel is stored.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL pass sense_in through a 2-flop synchronizer; sense_s refers to the synchronized bit.
REQ-016 SHALL implement states IDLE, DRIVE, SAMPLE and STORE, with a channel index ch and an 8-bit timer.
REQ-017 IDLE: ch=0 and drive_oe=0; when enable=1, SHALL go to DRIVE next cycle with timer=0.
REQ-018 DRIVE: drive_oe[ch]=1 for exactly DRIVE_CYCLES cycles; SHALL then go to SAMPLE with timer=0 and drive_oe=0.
REQ-019 SAMPLE: each cycle with sense_s[ch]=0 and timer<255, timer SHALL increment.
REQ-020 SAMPLE SHALL go to STORE when sense_s[ch]=1, or when timer=255 (timeout, saturated value 255).
REQ-021 STORE: single cycle; SHALL load count=timer and count_ch=ch, pulse count_valid, and update touched[ch].
REQ-022 After STORE, if ch<NUM_CH-1 the block SHALL set ch=ch+1 and go to DRIVE.
REQ-023 After STORE of the last channel, the block SHALL pulse scan_done in the following cycle and go to IDLE.
REQ-024 Deasserting enable mid-scan SHALL NOT abort; the current scan completes, then the block stays in IDLE.
REQ-025 IDLE SHALL last at least 1 cycle between scans; drive_oe SHALL never have more than one bit set.
REQ-026 Sensitivity without baseline: touched[ch] = (count > THRESH).

Reset
REQ-027 reset=0 on a rising edge SHALL force IDLE, with ch=0, timer=0 and synchronizer=0.
REQ-028 reset=0 SHALL force drive_oe=0, count=0, count_ch=0, count_valid=0, touched=0, scan_done=0 and busy=0.
REQ-029 reset=0 SHALL clear all baselines and baseline-valid flags.
REQ-030 Reset mid-DRIVE or mid-SAMPLE SHALL release drive_oe in the same edge, with no partial STORE.

Configuration
REQ-031 Macro CAP_SCAN_BASELINE_EN SHALL compile in per-channel 8-bit baseline registers with valid flags.
REQ-032 With CAP_SCAN_BASELINE_EN, the first STORE per channel after reset SHALL load baseline=count, set valid, and force touched[ch]=0.
REQ-033 Thereafter, with CAP_SCAN_BASELINE_EN, touched[ch] = (count > baseline+THRESH), computed 9-bit so there is no wrap.
REQ-034 With CAP_SCAN_BASELINE_EN and touched[ch]=0, baseline SHALL move by ±1 toward count (unchanged if equal); when touched, baseline is frozen.
REQ-035 Without CAP_SCAN_BASELINE_EN, REQ-026 applies and no baseline storage is synthesized.

Verification
REQ-036 Defaults, enable=1, every sense_s rising 40 cycles after drive_oe falls -> four strobes with count=40 and count_ch 0,1,2,3, then scan_done, touched=0000.
REQ-037 Channel 2 sense held low -> count=255 for ch 2 (timeout); without the macro touched=0100.
REQ-038 Each drive_oe pulse is 3 cycles long and one-hot; drive_oe=0 in IDLE, SAMPLE and STORE.
REQ-039 enable dropped during ch 1 SAMPLE -> ch 2 and 3 are still stored, scan_done pulses, busy=0, and no further drive_oe.
REQ-040 reset=0 asserted mid-SAMPLE of ch 1 -> next cycle all outputs are 0 and the block is in IDLE; after release, the scan restarts at ch 0.
REQ-041 CAP_SCAN_BASELINE_EN with samples 50,50,60,170 on ch 0 -> baselines 50,50,51 and touched=0,0,0,1 at the fourth sample (170>51+115).

Source files
------------

// File: rtl/cap_scan_ctrl.sv
// Capacitive touch scanner: per channel, drive the pad low, release it, time the recharge, store count/touch.
// Latency: DRIVE_CYCLES + recharge time (max 255) + 2 cycles per channel; scan_done one cycle after last STORE.
// No backpressure: count_valid/scan_done are unconditioned strobes. Optional CAP_SCAN_BASELINE_EN adds baselines.
module cap_scan_ctrl #(
    parameter int NUM_CH       = 4,
    parameter int DRIVE_CYCLES = 3,
    parameter int THRESH       = 115
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] sense_in,
    output logic [NUM_CH-1:0] drive_oe,
    output logic [7:0]        count,
    output logic [2:0]        count_ch,
    output logic              count_valid,
    output logic [NUM_CH-1:0] touched,
    output logic              scan_done,
    output logic              busy
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, STORE} state_t;

    state_t            state;
    logic [NUM_CH-1:0] sync_1;
    logic [NUM_CH-1:0] sense_s;
    logic [CH_W-1:0]   ch;
    logic [CH_W-1:0]   ch_next;
    logic [7:0]        timer;
    logic              hit;
    logic              last_ch;

    assign ch_next = ch + 1'b1;
    assign last_ch = (ch == CH_W'(NUM_CH - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_1  <= '0;
            sense_s <= '0;
        end else begin
            sync_1  <= sense_in;
            sense_s <= sync_1;
        end
    end

`ifdef CAP_SCAN_BASELINE_EN
    logic [7:0]        baseline [NUM_CH];
    logic [NUM_CH-1:0] bl_valid;
    logic [8:0]        bl_limit;

    // 9-bit sum so a high baseline cannot wrap below the sample
    assign bl_limit = {1'b0, baseline[ch]} + 9'(THRESH);
    assign hit      = bl_valid[ch] && ({1'b0, timer} > bl_limit);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                baseline[i] <= '0;
            end
            bl_valid <= '0;
        end else if (state == STORE) begin
            if (!bl_valid[ch]) begin
                baseline[ch] <= timer;
                bl_valid[ch] <= 1'b1;
            end else if (!hit) begin
                if (timer > baseline[ch]) begin
                    baseline[ch] <= baseline[ch] + 8'd1;
                end else if (timer < baseline[ch]) begin
                    baseline[ch] <= baseline[ch] - 8'd1;
                end
            end
        end
    end
`else
    assign hit = (timer > 8'(THRESH));
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            ch          <= '0;
            timer       <= '0;
            drive_oe    <= '0;
            count       <= '0;
            count_ch    <= '0;
            count_valid <= 1'b0;
            touched     <= '0;
            scan_done   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            scan_done   <= 1'b0;
            case (state)
                IDLE: begin
                    ch       <= '0;
                    drive_oe <= '0;
                    if (enable) begin
                        state    <= DRIVE;
                        timer    <= '0;
                        drive_oe <= NUM_CH'(1);
                        busy     <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (timer == 8'(DRIVE_CYCLES - 1)) begin
                        state    <= SAMPLE;
                        timer    <= '0;
                        drive_oe <= '0;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                SAMPLE: begin
                    // timer saturates at 255 as the timeout value
                    if (sense_s[ch] || (timer == 8'hFF)) begin
                        state <= STORE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                STORE: begin
                    count       <= timer;
                    count_ch    <= 3'(ch);
                    count_valid <= 1'b1;
                    touched[ch] <= hit;
                    if (last_ch) begin
                        state     <= IDLE;
                        ch        <= '0;
                        scan_done <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state    <= DRIVE;
                        ch       <= ch_next;
                        timer    <= '0;
                        drive_oe <= NUM_CH'(1) << ch_next;
                    end
                end
                default: begin
                    state    <= IDLE;
                    drive_oe <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cap_scan_ctrl.sv
// Bench for cap_scan_ctrl: a pad model answers drive_oe with programmable recharge delays,
// a behavioural model predicts every stored sample, and directed scenarios pin literal values.
module tb_cap_scan_ctrl;

    localparam int NUM_CH       = 4;
    localparam int DRIVE_CYCLES = 3;
    localparam int THRESH       = 115;
    localparam int BUDGET       = 3000;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b0;
    logic [NUM_CH-1:0] sense_in = '1;
    logic [NUM_CH-1:0] drive_oe;
    logic [7:0]        count;
    logic [2:0]        count_ch;
    logic              count_valid;
    logic [NUM_CH-1:0] touched;
    logic              scan_done;
    logic              busy;

    cap_scan_ctrl #(
        .NUM_CH(NUM_CH),
        .DRIVE_CYCLES(DRIVE_CYCLES),
        .THRESH(THRESH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .sense_in(sense_in),
        .drive_oe(drive_oe),
        .count(count),
        .count_ch(count_ch),
        .count_valid(count_valid),
        .touched(touched),
        .scan_done(scan_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int dly [NUM_CH];   // cycles from pad release until the synchronized level reads 1
    int log_cnt [$];
    int log_ch [$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pad: held low while driven; after release the raw pin rises two cycles before the
    // synchronized copy does, so the synchronized rise lands dly[c] cycles after release.
    logic [NUM_CH-1:0] prev_oe = '0;
    int  pn [NUM_CH];
    bit  armed [NUM_CH];
    always @(negedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (drive_oe[c]) begin
                sense_in[c] = 1'b0;
                armed[c] = 1'b0;
            end else if (prev_oe[c]) begin
                pn[c] = 0;
                armed[c] = 1'b1;
            end else if (armed[c]) begin
                pn[c]++;
            end
            if (armed[c] && !drive_oe[c] && pn[c] >= dly[c] - 2) begin
                sense_in[c] = 1'b1;
                armed[c] = 1'b0;
            end
        end
        prev_oe = drive_oe;
    end

    // Behavioural model: channels are visited in order, each sample is the recharge delay
    // clipped at 255, and the touch decision follows from the sample history.
    int exp_ch = 0;
    int strobes = 0;
    int oe_len = 0;
    int want = 0;
    int t = 0;
    logic [NUM_CH-1:0] exp_touch = '0;
    int  bl [NUM_CH];
    bit  blv [NUM_CH];

    always @(negedge clk) begin
        if (!reset) begin
            exp_ch = 0;
            strobes = 0;
            oe_len = 0;
            exp_touch = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                blv[c] = 1'b0;
                bl[c] = 0;
            end
        end else begin
            check("drive_oe_onehot", int'($countones(drive_oe) <= 1), 1);
            if (!busy) check("drive_oe_when_idle", int'(drive_oe), 0);
            if (drive_oe != '0) begin
                oe_len++;
            end else if (oe_len != 0) begin
                check("drive_pulse_len", oe_len, DRIVE_CYCLES);
                oe_len = 0;
            end
            if (count_valid) begin
                want = (dly[exp_ch] > 255) ? 255 : dly[exp_ch];
`ifdef CAP_SCAN_BASELINE_EN
                if (!blv[exp_ch]) begin
                    bl[exp_ch] = want;
                    blv[exp_ch] = 1'b1;
                    t = 0;
                end else begin
                    t = int'(want > bl[exp_ch] + THRESH);
                    if (t == 0) begin
                        if (want > bl[exp_ch]) bl[exp_ch]++;
                        else if (want < bl[exp_ch]) bl[exp_ch]--;
                    end
                end
`else
                t = int'(want > THRESH);
`endif
                exp_touch[exp_ch] = t[0];
                check("count", int'(count), want);
                check("count_ch", int'(count_ch), exp_ch);
                check("touched", int'(touched), int'(exp_touch));
                log_cnt.push_back(int'(count));
                log_ch.push_back(int'(count_ch));
                strobes++;
                exp_ch = (exp_ch + 1) % NUM_CH;
            end
            if (scan_done) begin
                check("scan_strobes", strobes, NUM_CH);
                check("busy_at_done", int'(busy), 0);
                strobes = 0;
            end
        end
    end

    task automatic wait_done(input string name);
        int k = 0;
        while (k < BUDGET && scan_done !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        check({name, "_done"}, int'(scan_done === 1'b1), 1);
    endtask

    task automatic run_scan(input string name);
        log_cnt.delete();
        log_ch.delete();
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_done(name);
        @(negedge clk);
    endtask

    task automatic wait_sample(input int c, input string name);
        int k = 0;
        while (k < BUDGET && drive_oe[c] !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        while (k < BUDGET && drive_oe[c] !== 1'b0) begin
            @(negedge clk);
            k++;
        end
        check({name, "_reach_sample"}, int'(k < BUDGET), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_drive_oe"}, int'(drive_oe), 0);
        check({name, "_count"}, int'(count), 0);
        check({name, "_count_ch"}, int'(count_ch), 0);
        check({name, "_count_valid"}, int'(count_valid), 0);
        check({name, "_touched"}, int'(touched), 0);
        check({name, "_scan_done"}, int'(scan_done), 0);
        check({name, "_busy"}, int'(busy), 0);
    endtask

    int seen_oe;
    int t0_seq [5] = '{50, 50, 60, 170, 160};
`ifdef CAP_SCAN_BASELINE_EN
    int t0_touch [5] = '{0, 0, 0, 1, 0};
`else
    int t0_touch [5] = '{0, 0, 0, 1, 1};
`endif

    initial begin
        for (int c = 0; c < NUM_CH; c++) dly[c] = 40;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;

        // Uniform 40-cycle recharge on every channel
        run_scan("uniform");
        check("uniform_n", log_cnt.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("uniform_cnt", (i < log_cnt.size()) ? log_cnt[i] : -1, 40);
            check("uniform_ch", (i < log_ch.size()) ? log_ch[i] : -1, i);
        end
        check("uniform_touched", int'(touched), 0);
        check("uniform_busy", int'(busy), 0);

        // Channel 2 never recharges: timeout saturates at 255
        dly[2] = 100000;
        run_scan("timeout");
        check("timeout_cnt2", (log_cnt.size() > 2) ? log_cnt[2] : -1, 255);
        check("timeout_cnt0", (log_cnt.size() > 0) ? log_cnt[0] : -1, 40);
        check("timeout_touched", int'(touched), 4'b0100);
        dly[2] = 40;

        // Enable dropped during channel 1 sampling: the scan still completes
        log_cnt.delete();
        log_ch.delete();
        @(negedge clk);
        enable = 1'b1;
        wait_sample(1, "enoff");
        enable = 1'b0;
        wait_done("enoff");
        @(negedge clk);
        check("enoff_n", log_ch.size(), 4);
        check("enoff_ch2", (log_ch.size() > 2) ? log_ch[2] : -1, 2);
        check("enoff_ch3", (log_ch.size() > 3) ? log_ch[3] : -1, 3);
        check("enoff_touched", int'(touched), 0);
        seen_oe = 0;
        repeat (60) begin
            @(negedge clk);
            if (drive_oe != '0 || busy) seen_oe++;
        end
        check("enoff_stays_idle", seen_oe, 0);

        // Reset mid-sample of channel 1, then restart from channel 0
        @(negedge clk);
        enable = 1'b1;
        wait_sample(1, "midrst");
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        log_cnt.delete();
        log_ch.delete();
        reset = 1'b1;
        seen_oe = 0;
        while (seen_oe < 20 && drive_oe == '0) begin
            @(negedge clk);
            seen_oe++;
        end
        check("restart_oe", int'(drive_oe), 4'b0001);
        enable = 1'b0;
        wait_done("restart");
        @(negedge clk);
        check("restart_first_ch", (log_ch.size() > 0) ? log_ch[0] : -1, 0);
        check("restart_n", log_ch.size(), 4);

        // Channel 0 sample history after a fresh reset
        do_reset();
        for (int s = 0; s < 5; s++) begin
            dly[0] = t0_seq[s];
            run_scan("hist");
            check("hist_cnt", (log_cnt.size() > 0) ? log_cnt[0] : -1, t0_seq[s]);
            check("hist_touch0", int'(touched[0]), t0_touch[s]);
`ifdef CAP_SCAN_BASELINE_EN
            if (s == 3) check("model_baseline0", bl[0], 51);
`endif
        end

        // Threshold boundary: one count above the limit touches, exactly at it does not
        dly[0] = 40;
`ifdef CAP_SCAN_BASELINE_EN
        dly[1] = 156;
        dly[3] = 155;
`else
        dly[1] = 116;
        dly[3] = 115;
`endif
        run_scan("edge");
        check("edge_touched", int'(touched), 4'b0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
